sysid_ext_qsys: RTL

//  Parametrised Avalon-MM system-ID/status slave, 2nd generation of the sysid block.

---
 rtl/sysid_pkg.sv | 24 ++
 rtl/sysid_uptime_counter.sv | 39 +++
 rtl/sysid_ext_qsys.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sysid_pkg.sv
// sysid_pkg: shared constants for the 2nd-generation system-ID slave.
// Word map, CAPS version and CTRL bit positions.
package sysid_pkg;

   localparam int DATA_W = 32;

   typedef logic [DATA_W-1:0] word_t;

   localparam int ADR_ID        = 0;
   localparam int ADR_TIMESTAMP = 1;
   localparam int ADR_CAPS      = 2;
   localparam int ADR_UPTIME_LO = 3;
   localparam int ADR_UPTIME_HI = 4;
   localparam int ADR_CTRL      = 5;
   localparam int ADR_SCRATCH0  = 6;

   localparam logic [7:0] CAPS_VERSION = 8'h02;

   localparam int CTRL_RUN    = 0;
   localparam int CTRL_CLEAR  = 1;
   localparam int CTRL_OVF    = 2;
   localparam int CTRL_IRQ_EN = 3;

endpackage

// File: rtl/sysid_uptime_counter.sv
// sysid_uptime_counter: prescaled free-running uptime counter.
// Clear beats increment; ovf pulses on the cycle the counter wraps.
module sysid_uptime_counter
   import sysid_pkg::*;
#(
   parameter int UPTIME_W = 64,
   parameter int TICK_DIV = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                run,
   input  logic                clear,
   output logic [UPTIME_W-1:0] count,
   output logic                ovf
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0] presc;
   logic          tick;

   assign tick = run && (presc == PW'(TICK_DIV - 1));
   assign ovf  = tick && (&count) && !clear;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         presc <= '0;
         count <= '0;
      end else if (clear) begin
         presc <= '0;
         count <= '0;
      end else if (run) begin
         presc <= tick ? '0 : presc + PW'(1);
         if (tick)
            count <= count + UPTIME_W'(1);
      end
   end

endmodule

// File: rtl/sysid_ext_qsys.sv
// sysid_ext_qsys: Avalon-MM system ID / uptime / status slave.
// RO ID words, coherent 64-bit uptime snapshot, CTRL and scratch regs.
module sysid_ext_qsys
   import sysid_pkg::*;
#(
   parameter logic [31:0] ID_VALUE     = 32'd18,
   parameter logic [31:0] TIMESTAMP    = 32'd1366147204,
   parameter int          ADDR_W       = 3,
   parameter int          UPTIME_W     = 64,
   parameter int          TICK_DIV     = 1,
   parameter int          NUM_SCRATCH  = 2,
   parameter int          READ_LATENCY = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       writedata,
   input  logic [3:0]        byteenable,
   output logic [31:0]       readdata,
   output logic              readdatavalid,
   output logic              irq
);

   localparam int HI_W = UPTIME_W - 32;
   localparam int NS   = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;

   logic [31:0]         adr;
   logic                wr_en;
   logic                ctrl_wr;
   logic                clear;
   logic                ovf;
   logic                run;
   logic                ovf_sticky;
   logic                irq_en;
   logic [UPTIME_W-1:0] uptime;
   logic [HI_W-1:0]     hi_snap;
   word_t               scratch [NS];
   word_t               rdata;
   logic                v1;
   word_t               d1;

   assign adr     = 32'(address);
   assign wr_en   = write && !read;
   assign ctrl_wr = wr_en && (adr == ADR_CTRL) && byteenable[0];
   assign clear   = ctrl_wr && writedata[CTRL_CLEAR];
   assign irq     = ovf_sticky && irq_en;

   sysid_uptime_counter #(
      .UPTIME_W(UPTIME_W),
      .TICK_DIV(TICK_DIV)
   ) u_uptime (
      .clock(clock),
      .reset(reset),
      .run  (run),
      .clear(clear),
      .count(uptime),
      .ovf  (ovf)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         run        <= 1'b1;
         ovf_sticky <= 1'b0;
         irq_en     <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            run    <= writedata[CTRL_RUN];
            irq_en <= writedata[CTRL_IRQ_EN];
         end
         // a wrap landing on the W1C cycle keeps the flag set
         if (ovf)
            ovf_sticky <= 1'b1;
         else if (ctrl_wr && writedata[CTRL_OVF])
            ovf_sticky <= 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         hi_snap <= '0;
      else if (read && adr == ADR_UPTIME_LO)
         hi_snap <= uptime[UPTIME_W-1:32];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NS; i++)
            scratch[i] <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < NUM_SCRATCH; i++)
            if (adr == 32'(ADR_SCRATCH0 + i))
               for (int b = 0; b < 4; b++)
                  if (byteenable[b])
                     scratch[i][8*b +: 8] <= writedata[8*b +: 8];
      end
   end

   always_comb begin
      rdata = '0;
      case (adr)
         ADR_ID:        rdata = ID_VALUE;
         ADR_TIMESTAMP: rdata = TIMESTAMP;
         ADR_CAPS:      rdata = {CAPS_VERSION, 8'(READ_LATENCY),
                                 8'(UPTIME_W), 8'(NUM_SCRATCH)};
         ADR_UPTIME_LO: rdata = uptime[31:0];
         ADR_UPTIME_HI: rdata = word_t'(hi_snap);
         ADR_CTRL: begin
            rdata[CTRL_RUN]    = run;
            rdata[CTRL_OVF]    = ovf_sticky;
            rdata[CTRL_IRQ_EN] = irq_en;
         end
         default: begin
            for (int i = 0; i < NUM_SCRATCH; i++)
               if (adr == 32'(ADR_SCRATCH0 + i))
                  rdata = scratch[i];
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         v1 <= 1'b0;
         d1 <= '0;
      end else begin
         v1 <= read;
         if (read)
            d1 <= rdata;
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_rl2
         logic  v2;
         word_t d2;
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               v2 <= 1'b0;
               d2 <= '0;
            end else begin
               v2 <= v1;
               if (v1)
                  d2 <= d1;
            end
         end
         assign readdata      = d2;
         assign readdatavalid = v2;
      end else begin : g_rl1
         assign readdata      = d1;
         assign readdatavalid = v1;
      end
   endgenerate

endmodule
